// File: rtl/ahb3lite_sram_slave.sv
// ahb3lite_sram_slave
//   AHB3-Lite responder in front of a word-organised on-chip memory. It is the
//   target for the DMA master ports. Byte, halfword and word transfers are
//   supported. A fixed number of wait states is inserted before every OKAY
//   completion. Illegal accesses get the two-cycle ERROR response.
//
// Ports
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   sHSEL, sHREADY      slave select / bus ready (previous transfer completed)
//   sHADDR, sHTRANS     address-phase byte address and transfer type
//   sHWRITE, sHSIZE     address-phase direction and size (0=byte,1=half,2=word)
//   sHBURST, sHPROT     accepted for port compatibility, not used
//   sHWDATA             data-phase write data
//   sHRDATA             read data; zero outside a read data cycle
//   sHREADYOUT, sHRESP  transfer-done and OKAY(0)/ERROR(1) response

module ahb3lite_sram_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sHSEL,
    input  logic [31:0] sHADDR,
    input  logic [31:0] sHWDATA,
    output logic [31:0] sHRDATA,
    input  logic        sHWRITE,
    input  logic [2:0]  sHSIZE,
    input  logic [2:0]  sHBURST,
    input  logic [3:0]  sHPROT,
    input  logic [1:0]  sHTRANS,
    output logic        sHREADYOUT,
    input  logic        sHREADY,
    output logic        sHRESP
);
    localparam int          AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(4 * MEM_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic [AW-1:0]  r_word;
    logic [3:0]     r_be;
    logic           r_write;
    logic [31:0]    r_rdata;
    logic           r_readyout;
    logic           r_resp;
    logic [31:0]    r_mem [MEM_WORDS];

    logic           w_accept;
    logic           w_sample;
    logic           w_go;
    logic           w_in_range;
    logic           w_aligned;
    logic           w_legal;
    logic [AW-1:0]  w_haddr_word;
    logic [3:0]     w_be;
    logic [31:0]    w_merged;
    logic           w_commit;
    logic [AW-1:0]  w_rd_word;
    logic [31:0]    w_rd_src;
    logic           w_unused;

    assign w_unused     = ^{sHBURST, sHPROT, sHTRANS[0]};

    // SEQ is handled exactly like NONSEQ: only HTRANS[1] matters.
    assign w_accept     = sHSEL & sHREADY & sHTRANS[1];
    // Address phases are only looked at in states that drive HREADYOUT high.
    assign w_sample     = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
    assign w_go         = w_sample & w_accept;

    // Full 32-bit address is range-checked; no aliasing of high bits.
    assign w_in_range   = ({1'b0, sHADDR} < LIMIT);
    assign w_aligned    = (sHSIZE == 3'd1) ? ~sHADDR[0] :
                          (sHSIZE == 3'd2) ? (sHADDR[1:0] == 2'b00) : 1'b1;
    assign w_legal      = w_in_range && (sHSIZE <= 3'd2) && w_aligned;
    assign w_haddr_word = sHADDR[AW+1:2];

    always_comb begin
        w_be = 4'b0000;
        case (sHSIZE)
            3'd0:    w_be = 4'b0001 << sHADDR[1:0];
            3'd1:    w_be = sHADDR[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_merged = r_mem[r_word];
        for (int b = 0; b < 4; b++) begin
            if (r_be[b]) w_merged[8*b +: 8] = sHWDATA[8*b +: 8];
        end
    end

    assign w_commit  = (r_state == S_DATA) && r_write;

    // A read entering DATA straight from an accept may target the word the
    // finishing write is committing this very edge; forward the merged value.
    assign w_rd_word = (r_state == S_WAIT) ? r_word : w_haddr_word;
    assign w_rd_src  = (w_commit && (r_word == w_rd_word)) ? w_merged : r_mem[w_rd_word];

    // Memory is not reset; a write in flight at reset is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_commit) r_mem[r_word] <= w_merged;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_word     <= '0;
            r_be       <= '0;
            r_write    <= 1'b0;
            r_rdata    <= '0;
            r_readyout <= 1'b1;
            r_resp     <= 1'b0;
        end else begin
            r_rdata    <= '0;
            r_readyout <= 1'b1;
            r_resp     <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DATA;
                        if (!r_write) r_rdata <= w_rd_src;
                    end else begin
                        r_cnt      <= r_cnt - 4'd1;
                        r_readyout <= 1'b0;
                    end
                end
                S_ERR1: begin
                    r_state <= S_ERR2;
                    r_resp  <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 all pick the next transfer the same way.
                    if (w_go) begin
                        r_word  <= w_haddr_word;
                        r_be    <= w_be;
                        r_write <= sHWRITE;
                        if (!w_legal) begin
                            r_state    <= S_ERR1;
                            r_readyout <= 1'b0;
                            r_resp     <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            r_state <= S_DATA;
                            if (!sHWRITE) r_rdata <= w_rd_src;
                        end else begin
                            r_state    <= S_WAIT;
                            r_cnt      <= 4'(WAIT_STATES - 1);
                            r_readyout <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign sHRDATA    = r_rdata;
    assign sHREADYOUT = r_readyout;
    assign sHRESP     = r_resp;

endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
AHB3-Lite responder backed by a word-organised on-chip memory. It is the target end of the DMA master ports (m0/m1): it gives the DMA masters a memory to read from and write to, and it serves as the bench target for the DMA subsystem. It supports:
- byte, halfword and word transfers
- a programmable number of wait states
- the two-cycle ERROR response for illegal accesses

Parameters:
MEM_WORDS, 1024, memory depth in 32-bit words; legal byte addresses are 0 to 4*MEM_WORDS-1 (address compared after masking to clog2(4*MEM_WORDS) bits is NOT done; full HADDR is checked).
WAIT_STATES, 0, number of HREADYOUT-low cycles inserted before completing each OKAY transfer (range 0..15).

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-high
sHSEL  input  1  slave select
sHADDR  input  32  byte address (address phase)
sHWDATA  input  32  write data (data phase)
sHRDATA  output  32  read data
sHWRITE  input  1  1=write, 0=read
sHSIZE  input  3  transfer size: 0=byte, 1=half, 2=word
sHBURST  input  3  ignored
sHPROT  input  4  ignored
sHTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
sHREADYOUT  output  1  slave ready / transfer complete
sHREADY  input  1  bus ready (previous transfer completed)
sHRESP  output  1  0=OKAY, 1=ERROR

Behaviour:
Interface:
- One clock, clk_i; reset rst_i is synchronous and active-high.

Reset:
- sHREADYOUT=1, sHRESP=0, sHRDATA=0, FSM=IDLE, no pending transfer.
- Memory contents are not reset.
- Reset asserted mid-transfer (any state) abandons the transfer.
- A pending write is not committed when reset is asserted.

Address-phase accept:
- A transfer is accepted when sHSEL & sHREADY & sHTRANS[1] at a rising edge.
- On accept, latch address, size and write flag.
- SEQ is treated as NONSEQ.
- IDLE/BUSY, or sHSEL=0, produce no data phase.

Legality check (at accept):
- ERROR if HADDR >= 4*MEM_WORDS.
- ERROR if sHSIZE>2.
- ERROR if misaligned: size 1 with HADDR[0]=1, or size 2 with HADDR[1:0]!=0.

FSM states:
- IDLE: sHREADYOUT=1, sHRESP=0.
  - Legal accept with WAIT_STATES=0 -> DATA.
  - Legal accept with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
  - Illegal accept -> ERR1.
- WAIT: sHREADYOUT=0, sHRESP=0.
  - Counter decrements each cycle; at 0 -> DATA.
  - New address phases are not sampled here (sHREADY is low).
- DATA: sHREADYOUT=1, sHRESP=0; the transfer completes this cycle.
  - Write: at the rising edge ending DATA, commit the enabled byte lanes of sHWDATA.
  - Read: sHRDATA = mem[latched word].
  - Next state is chosen as from IDLE, so back-to-back pipelined transfers are sustained with zero idle cycles when WAIT_STATES=0.
- ERR1: sHREADYOUT=0, sHRESP=1 -> ERR2.
- ERR2: sHREADYOUT=1, sHRESP=1. Accept evaluated as in IDLE (the master may have issued IDLE instead).
- Error transfers never insert wait states and never modify memory.

Byte lanes (little-endian):
- Size 0: lane HADDR[1:0].
- Size 1: lanes {HADDR[1],0} and {HADDR[1],1}.
- Size 2: all four lanes.
- Read returns the full word regardless of size.

Read data and hazards:
- sHRDATA is 0 in every cycle other than a read DATA cycle.
- Write then read of the same word on consecutive transfers returns the newly written data (no stale read).

Test Plan:
1. WAIT_STATES=0: NONSEQ word write 0x10 data 0xDEADBEEF, immediately followed by a pipelined read of 0x10 -> sHREADYOUT stays 1 throughout, read DATA cycle sHRDATA=0xDEADBEEF, sHRESP=0.
2. Word write 0x0=0x11223344; byte write 0x2 with HWDATA=0x00AB0000; halfword write 0x0 with HWDATA=0x0000CDEF; read 0x0 -> 0x11ABCDEF.
3. WAIT_STATES=2: read 0x10 -> sHREADYOUT low exactly 2 cycles, then high 1 cycle with sHRDATA=0xDEADBEEF; sHRDATA=0 during wait cycles.
4. MEM_WORDS=1024: write to 0x1000 -> sHRESP=1 for 2 cycles, with sHREADYOUT 0 then 1; a subsequent read of 0x0 returns the unchanged contents.
5. Halfword access at 0x1, and a size-3 access at 0x0 -> each gets the two-cycle ERROR response; IDLE and BUSY transfers get an OKAY response with no wait states and no memory change.
6. WAIT_STATES=3: write 0x20=0xCAFEF00D, then assert rst_i during the 2nd wait cycle -> next cycle sHREADYOUT=1, sHRESP=0, sHRDATA=0; a read of 0x20 does not return 0xCAFEF00D (location pre-written with 0x0 before the test).
